// File: rtl/sine_pkg.sv
// Shared constants and enums for the sine generator/analyzer pair.
package sine_pkg;

    localparam int DATA_W = 8;
    localparam int MID    = 128;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_e;

    typedef enum logic {
        LO = 1'b0,
        HI = 1'b1
    } pol_e;

endpackage

// File: rtl/sine_analyzer_if.sv
// Sample stream in, period/peak measurement results out.
interface sine_analyzer_if #(
    parameter int DATA_W   = 8,
    parameter int PERIOD_W = 16
);
    logic [DATA_W-1:0]   sample_in;
    logic                sample_valid;
    logic [PERIOD_W-1:0] period_out;
    logic [DATA_W-1:0]   max_out;
    logic [DATA_W-1:0]   min_out;
    logic                result_valid;
    logic                locked;
    logic                timeout;

    modport master (
        output sample_in, sample_valid,
        input  period_out, max_out, min_out, result_valid, locked, timeout
    );

    modport slave (
        input  sample_in, sample_valid,
        output period_out, max_out, min_out, result_valid, locked, timeout
    );
endinterface

// File: rtl/sine_xing_det.sv
// Hysteresis polarity tracker; flags rising mid-scale crossings on valid beats.
module sine_xing_det
    import sine_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int MID    = 128,
    parameter int HYST   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_i,
    input  logic              valid_i,
    input  logic              clear_i,
    output logic              rise_o,
    output logic              pol_valid_o
);

    localparam logic [DATA_W-1:0] HI_TH = DATA_W'(MID + HYST);
    localparam logic [DATA_W-1:0] LO_TH = DATA_W'(MID - HYST);

    pol_e pol_q, pol_d;
    logic pol_valid_q, pol_valid_d;
    logic hi_s, lo_s;

    assign hi_s = (sample_i >= HI_TH);
    assign lo_s = (sample_i <= LO_TH);

    // Next polarity: in-band samples leave pol untouched; clear forgets it entirely.
    always_comb begin
        pol_d       = pol_q;
        pol_valid_d = pol_valid_q;
        if (clear_i) begin
            pol_valid_d = 1'b0;
        end else if (valid_i && hi_s) begin
            pol_d       = HI;
            pol_valid_d = 1'b1;
        end else if (valid_i && lo_s) begin
            pol_d       = LO;
            pol_valid_d = 1'b1;
        end else begin
            pol_d       = pol_q;
        end
    end

    assign rise_o      = valid_i && pol_valid_q && (pol_q == LO) && hi_s;
    assign pol_valid_o = pol_valid_d;

    // Polarity state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pol_q       <= LO;
            pol_valid_q <= 1'b0;
        end else begin
            pol_q       <= pol_d;
            pol_valid_q <= pol_valid_d;
        end
    end

endmodule

// File: rtl/sine_analyzer.sv
// Measures period, peaks and lock of an offset-binary sample stream.
module sine_analyzer
    import sine_pkg::*;
#(
    parameter int DATA_W     = sine_pkg::DATA_W,
    parameter int MID        = sine_pkg::MID,
    parameter int HYST       = 4,
    parameter int PERIOD_W   = 16,
    parameter int MAX_PERIOD = 65535,
    parameter int LOCK_TOL   = 1
) (
    input  logic           clk,
    input  logic           rst,
    sine_analyzer_if.slave bus
);

    localparam logic [PERIOD_W:0] LIMIT = (PERIOD_W+1)'(MAX_PERIOD);
    localparam logic [PERIOD_W:0] TOL   = (PERIOD_W+1)'(LOCK_TOL);

    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d, prev_q, prev_d, period_q, period_d;
    logic                prev_valid_q, prev_valid_d;
    logic [DATA_W-1:0]   max_acc_q, max_acc_d, min_acc_q, min_acc_d;
    logic [DATA_W-1:0]   max_q, max_d, min_q, min_d;
    logic                rv_q, rv_d, locked_q, locked_d, to_q, to_d;

    logic              valid_s, rise_s, pol_valid_s, lim_hit_s;
    logic [DATA_W-1:0] smp_s;
    logic [PERIOD_W:0] diff_s;

    assign valid_s = bus.sample_valid;
    assign smp_s   = bus.sample_in;

    sine_xing_det #(
        .DATA_W (DATA_W),
        .MID    (MID),
        .HYST   (HYST)
    ) u_xing (
        .clk         (clk),
        .rst         (rst),
        .sample_i    (smp_s),
        .valid_i     (valid_s),
        .clear_i     (lim_hit_s),
        .rise_o      (rise_s),
        .pol_valid_o (pol_valid_s)
    );

    // A crossing on the limit beat wins, so only non-crossing samples can time out.
    assign lim_hit_s = valid_s && !rise_s && (state_q != SEARCH)
                       && (({1'b0, cnt_q} + {{PERIOD_W{1'b0}}, 1'b1}) == LIMIT);
    assign diff_s    = (cnt_q >= prev_q) ? ({1'b0, cnt_q} - {1'b0, prev_q})
                                         : ({1'b0, prev_q} - {1'b0, cnt_q});

    // Next-state logic for the search/arm/measure sequence.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        max_acc_d    = max_acc_q;
        min_acc_d    = min_acc_q;
        period_d     = period_q;
        max_d        = max_q;
        min_d        = min_q;
        locked_d     = locked_q;
        rv_d         = 1'b0;
        to_d         = 1'b0;
        if (!valid_s) begin
            state_d = state_q;
        end else if (state_q == SEARCH) begin
            if (pol_valid_s) begin
                state_d = ARM;
                cnt_d   = '0;
            end else begin
                state_d = SEARCH;
            end
        end else if (rise_s) begin
            if (state_q == MEASURE) begin
                period_d     = cnt_q;
                max_d        = max_acc_q;
                min_d        = min_acc_q;
                rv_d         = 1'b1;
                locked_d     = prev_valid_q && (diff_s <= TOL);
                prev_d       = cnt_q;
                prev_valid_d = 1'b1;
            end else begin
                rv_d = 1'b0;
            end
            state_d   = MEASURE;
            cnt_d     = {{(PERIOD_W-1){1'b0}}, 1'b1};
            max_acc_d = smp_s;
            min_acc_d = smp_s;
        end else if (lim_hit_s) begin
            to_d         = 1'b1;
            locked_d     = 1'b0;
            prev_valid_d = 1'b0;
            state_d      = SEARCH;
        end else begin
            cnt_d     = cnt_q + {{(PERIOD_W-1){1'b0}}, 1'b1};
            max_acc_d = (smp_s > max_acc_q) ? smp_s : max_acc_q;
            min_acc_d = (smp_s < min_acc_q) ? smp_s : min_acc_q;
        end
    end

    // State and output registers; reset discards any partial period.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SEARCH;
            cnt_q        <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            max_acc_q    <= '0;
            min_acc_q    <= '0;
            period_q     <= '0;
            max_q        <= '0;
            min_q        <= '0;
            rv_q         <= 1'b0;
            locked_q     <= 1'b0;
            to_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            max_acc_q    <= max_acc_d;
            min_acc_q    <= min_acc_d;
            period_q     <= period_d;
            max_q        <= max_d;
            min_q        <= min_d;
            rv_q         <= rv_d;
            locked_q     <= locked_d;
            to_q         <= to_d;
        end
    end

    assign bus.period_out   = period_q;
    assign bus.max_out      = max_q;
    assign bus.min_out      = min_q;
    assign bus.result_valid = rv_q;
    assign bus.locked       = locked_q;
    assign bus.timeout      = to_q;

endmodule

// File: tb/tb_sine_analyzer.sv
// Directed self-checking bench for sine_analyzer (default and short-timeout instances).
module tb_sine_analyzer;
    import sine_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sine_analyzer_if #(.DATA_W(8), .PERIOD_W(16)) bus_a ();
    sine_analyzer_if #(.DATA_W(8), .PERIOD_W(16)) bus_b ();

    sine_analyzer #(.MAX_PERIOD(65535)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    sine_analyzer #(.MAX_PERIOD(64))    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int vectors    = 0;
    int miscompares = 0;
    int rv_cnt  = 0;
    int to_cnt  = 0;
    int tob_cnt = 0;
    logic [15:0] res_period = 16'd0;
    logic [7:0]  res_max    = 8'd0;
    logic [7:0]  res_min    = 8'd0;
    logic        res_locked = 1'b0;
    logic [7:0]  tbl [32];
    logic [7:0]  tmax, tmin;

    task automatic beat(input logic v, input logic [7:0] s);
        bus_a.sample_valid = v;
        bus_a.sample_in    = s;
        bus_b.sample_valid = v;
        bus_b.sample_in    = s;
        @(posedge clk);
        #1;
        if (bus_a.result_valid) begin
            rv_cnt++;
            res_period = bus_a.period_out;
            res_max    = bus_a.max_out;
            res_min    = bus_a.min_out;
            res_locked = bus_a.locked;
        end
        if (bus_a.timeout) to_cnt++;
        if (bus_b.timeout) tob_cnt++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic period(input int len);
        for (int i = 0; i < len; i++) beat(1'b1, (i < 10) ? 8'd200 : 8'd50);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        beat(1'b1, 8'd200);
        rst = 1'b0;
        rv_cnt = 0; to_cnt = 0; tob_cnt = 0;
    endtask

    initial begin
        bus_a.sample_valid = 1'b0; bus_a.sample_in = 8'd0;
        bus_b.sample_valid = 1'b0; bus_b.sample_in = 8'd0;

        // reset with random traffic
        rst = 1'b1;
        for (int i = 0; i < 5; i++) beat(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        chk("rst_period", 32'(bus_a.period_out), 32'd0);
        chk("rst_max",    32'(bus_a.max_out),    32'd0);
        chk("rst_min",    32'(bus_a.min_out),    32'd0);
        chk("rst_rv",     32'(bus_a.result_valid), 32'd0);
        chk("rst_locked", 32'(bus_a.locked),     32'd0);
        chk("rst_to",     32'(bus_a.timeout),    32'd0);
        rst = 1'b0;
        rv_cnt = 0; to_cnt = 0; tob_cnt = 0;

        // square wave: arm, first crossing, then first result
        period(20);
        period(20);
        chk("sq_no_early", 32'(rv_cnt), 32'd0);
        beat(1'b1, 8'd200);
        chk("sq1_rv",     32'(bus_a.result_valid), 32'd1);
        chk("sq1_period", 32'(bus_a.period_out),   32'd20);
        chk("sq1_max",    32'(bus_a.max_out),      32'd200);
        chk("sq1_min",    32'(bus_a.min_out),      32'd50);
        chk("sq1_locked", 32'(bus_a.locked),       32'd0);
        for (int i = 1; i < 20; i++) beat(1'b1, (i < 10) ? 8'd200 : 8'd50);
        chk("sq2_quiet", 32'(bus_a.result_valid), 32'd0);
        beat(1'b1, 8'd200);
        chk("sq2_rv",     32'(bus_a.result_valid), 32'd1);
        chk("sq2_locked", 32'(bus_a.locked),       32'd1);
        for (int i = 1; i < 20; i++) beat(1'b1, (i < 10) ? 8'd200 : 8'd50);

        // every third cycle invalid with a junk sample of 0
        rv_cnt = 0;
        begin
            int ph;
            ph = 0;
            for (int c = 0; c < 90; c++) begin
                if (c % 3 == 2) begin
                    beat(1'b0, 8'd0);
                    chk("gap_no_rv", 32'(bus_a.result_valid), 32'd0);
                end else begin
                    beat(1'b1, (ph < 10) ? 8'd200 : 8'd50);
                    ph = (ph + 1) % 20;
                end
            end
        end
        chk("gap_count",  32'(rv_cnt),     32'd3);
        chk("gap_period", 32'(res_period), 32'd20);
        chk("gap_max",    32'(res_max),    32'd200);
        chk("gap_min",    32'(res_min),    32'd50);
        chk("gap_locked", 32'(res_locked), 32'd1);

        // lock tolerance: periods 20, 21, 23
        do_reset();
        period(20);
        period(20);
        period(21);
        chk("tol20_cnt", 32'(rv_cnt), 32'd1);
        chk("tol20_per", 32'(res_period), 32'd20);
        chk("tol20_lck", 32'(res_locked), 32'd0);
        period(23);
        chk("tol21_cnt", 32'(rv_cnt), 32'd2);
        chk("tol21_per", 32'(res_period), 32'd21);
        chk("tol21_lck", 32'(res_locked), 32'd1);
        period(20);
        chk("tol23_cnt", 32'(rv_cnt), 32'd3);
        chk("tol23_per", 32'(res_period), 32'd23);
        chk("tol23_lck", 32'(res_locked), 32'd0);

        // reset mid-period, then a fresh start
        for (int i = 0; i < 7; i++) beat(1'b1, 8'd200);
        do_reset();
        chk("mid_rst_period", 32'(bus_a.period_out), 32'd0);
        chk("mid_rst_max",    32'(bus_a.max_out),    32'd0);
        chk("mid_rst_min",    32'(bus_a.min_out),    32'd0);
        chk("mid_rst_locked", 32'(bus_a.locked),     32'd0);
        period(20);
        period(20);
        period(20);
        chk("fresh_cnt", 32'(rv_cnt), 32'd1);
        chk("fresh_per", 32'(res_period), 32'd20);
        chk("fresh_lck", 32'(res_locked), 32'd0);
        beat(1'b1, 8'd200);
        chk("fresh2_lck", 32'(bus_a.locked), 32'd1);

        // in-band toggling never defines polarity
        do_reset();
        for (int i = 0; i < 1000; i++) beat(1'b1, (i % 2 == 0) ? 8'd126 : 8'd130);
        chk("hyst_rv",    32'(rv_cnt),  32'd0);
        chk("hyst_to_a",  32'(to_cnt),  32'd0);
        chk("hyst_to_b",  32'(tob_cnt), 32'd0);
        chk("hyst_state", 32'(dut_a.state_q), 32'(SEARCH));

        // timeout on the MAX_PERIOD=64 instance
        do_reset();
        repeat (4) period(20);
        beat(1'b1, 8'd200);
        chk("to_prelock", 32'(bus_b.locked), 32'd1);
        repeat (62) beat(1'b1, 8'd200);
        chk("to_none_yet", 32'(tob_cnt), 32'd0);
        beat(1'b1, 8'd200);
        chk("to_pulse",  32'(bus_b.timeout),      32'd1);
        chk("to_locked", 32'(bus_b.locked),       32'd0);
        chk("to_period", 32'(bus_b.period_out),   32'd20);
        chk("to_rv",     32'(bus_b.result_valid), 32'd0);
        chk("to_state",  32'(dut_b.state_q),      32'(SEARCH));
        beat(1'b1, 8'd200);
        chk("to_single", 32'(bus_b.timeout), 32'd0);
        repeat (10) beat(1'b1, 8'd200);
        chk("to_count", 32'(tob_cnt), 32'd1);

        // 32-entry sine table as from the generator
        for (int k = 0; k < 32; k++)
            tbl[k] = 8'($rtoi(128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * k / 32.0)));
        tmax = 8'd0;
        tmin = 8'd255;
        for (int k = 0; k < 32; k++) begin
            if (tbl[k] > tmax) tmax = tbl[k];
            if (tbl[k] < tmin) tmin = tbl[k];
        end
        do_reset();
        for (int n = 0; n < 6 * 32; n++) beat(1'b1, tbl[n % 32]);
        chk("sine_cnt",    32'(rv_cnt),     32'd4);
        chk("sine_period", 32'(res_period), 32'd32);
        chk("sine_max",    32'(res_max),    32'(tmax));
        chk("sine_min",    32'(res_min),    32'(tmin));
        chk("sine_locked", 32'(res_locked), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sine_analyzer.md
Name: sine_analyzer

Overview:
- Consumer-side counterpart of sine_generator: takes the 8-bit offset-binary sample stream and recovers waveform properties.
- Detects rising mid-scale crossings with hysteresis.
- Per period, reports the period length in samples and the peak maximum and minimum.
- Asserts lock when successive periods agree; flags loss of signal by timeout.
- Sits directly on the sine_out bus, or on any DAC-bound sample stream, as a built-in self-check and monitor.

Parameters:
- DATA_W, 8: sample width, unsigned offset binary.
- MID, 128: mid-scale crossing threshold.
- HYST, 4: hysteresis half-band. Requires HYST < MID and MID+HYST < 2**DATA_W.
- PERIOD_W, 16: width of the period counter and of period_out.
- MAX_PERIOD, 65535: timeout limit in valid samples. Must be ≤ 2**PERIOD_W-1.
- LOCK_TOL, 1: maximum |period - previous period| counted as a match.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous reset, active-high.
- sample_in, input, DATA_W: sample value, sampled only when sample_valid=1.
- sample_valid, input, 1: sample qualifier. Gaps are allowed.
- period_out, output, PERIOD_W: last measured period in valid samples.
- max_out, output, DATA_W: largest sample in the last period.
- min_out, output, DATA_W: smallest sample in the last period.
- result_valid, output, 1: one-cycle pulse when period_out, max_out and min_out update.
- locked, output, 1: two consecutive periods match within LOCK_TOL.
- timeout, output, 1: one-cycle pulse on loss of signal.

Behaviour:
- Reset, synchronous, active-high, on clk:
  - All outputs become 0 and the FSM goes to SEARCH.
  - Reset dominates every other event, including mid-period. Any partial period is discarded.
- Only cycles with sample_valid=1 advance any state. Invalid cycles hold all internal state; result_valid and timeout stay 0.
- Polarity register pol, with hysteresis:
  - HI when sample ≥ MID+HYST.
  - LO when sample ≤ MID-HYST.
  - Otherwise pol is unchanged.
  - Rising crossing = a valid sample that changes pol from LO to HI.
- FSM states and transitions:
  - SEARCH: pol undefined. First sample outside the band sets pol and moves to ARM.
  - ARM: waits for the first rising crossing. On the crossing: cnt←1, max/min accumulators←sample, go to MEASURE.
  - ARM has no result output. cnt counts valid samples in ARM for timeout.
  - MEASURE, non-crossing sample: cnt←cnt+1; max_acc←max(max_acc,sample); min_acc←min(min_acc,sample).
  - MEASURE, crossing sample:
    - period_out←cnt, max_out←max_acc, min_out←min_acc. The crossing sample belongs to the next period.
    - result_valid=1 in the following cycle. Latency is 1 clock from the crossing beat.
    - Then cnt←1 and accumulators←sample.
- Period definition: count of valid samples from one crossing sample (inclusive) to the next crossing sample (exclusive).
- Timeout:
  - In ARM or MEASURE, a valid non-crossing sample that would make cnt reach MAX_PERIOD pulses timeout the next cycle.
  - On timeout: locked←0, FSM→SEARCH, no result_valid. period_out, max_out and min_out hold their last values.
  - A crossing on the same beat as the limit wins: no timeout.
- Lock:
  - On each result, compare period_out against the previous result: locked←1 if |new-prev| ≤ LOCK_TOL, else 0.
  - The first result after SEARCH has no previous result, so locked stays 0.
  - prev is cleared on entry to SEARCH.
  - locked updates on the same clock edge as result_valid.
- Arithmetic: unsigned comparisons throughout. cnt never wraps, because timeout fires first. The |diff| compare is computed at PERIOD_W+1 bits.
- Samples inside the band never change pol, so a signal with amplitude below HYST yields no results.

Decomposition:
- Package sine_pkg: DATA_W, MID; state enum (SEARCH, ARM, MEASURE); polarity enum (LO, HI). Shared with sine_generator's constants.
- One sub-module: sine_xing_det. Holds the hysteresis polarity register and outputs rise_pulse and pol_valid.
- FSM, counter, accumulators and lock compare live in the top level.

Test Plan:
- Reset: hold rst 5 cycles with random sample_valid and sample_in, then release → all outputs 0. No result_valid until two rising crossings have occurred.
- Square stimulus, 10×200 then 10×50, repeated continuously:
  - First result_valid one cycle after the 2nd rising crossing: period_out=20, max_out=200, min_out=50, locked=0.
  - The next result sets locked=1.
- Valid gaps: same stimulus with sample_valid=0 on every 3rd cycle → identical period_out=20, max=200, min=50. Only result_valid timing stretches.
- Hysteresis: alternate 126/130 for 1000 samples → pol never defined, FSM stays in SEARCH, zero result_valid, zero timeout.
- Timeout with MAX_PERIOD=64 override: lock on the square wave, then hold 200 →
  - single timeout pulse one cycle after the 63rd valid held sample;
  - locked=0, FSM returns to SEARCH;
  - period_out holds 20.
- Lock tolerance and reset mid-period:
  - Periods 20, 21, 23 → locked 0→1→0.
  - Assert rst after 7 samples of a period → outputs 0 next cycle; the following results match a fresh start.
  - Driving sine_generator output → stable locked=1 with max_out and min_out equal to its table extremes.
